// File: rtl/fifo_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_ram                                                     |
// | Description : Simple dual-port RAM, synchronous write, registered read.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Read-before-write: a same-address read returns the old word, which the
  // full FIFO relies on when it pops and pushes in one cycle.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)  r_rd_data <= '0;
    else if (re)  r_rd_data <= r_mem[raddr];
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_fifo                                                    |
// | Description : Single-clock FIFO with registered count, flags, err pulses.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module sync_fifo #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = (1 << ADDR_W) - 2
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] C_DEPTH    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] C_AF_LEVEL = (ADDR_W+1)'(AF_LEVEL);

  logic [ADDR_W:0] r_wr_ptr, r_rd_ptr, r_count;
  logic            r_full, r_empty, r_almost_full;
  logic            r_rd_valid, r_overflow, r_underflow;
  logic            w_rd_ok, w_wr_ok;
  logic [ADDR_W:0] w_wr_ptr_nxt, w_rd_ptr_nxt, w_count_nxt;

  assign w_rd_ok      = rd_en && !r_empty;
  assign w_wr_ok      = wr_en && (!r_full || w_rd_ok);
  assign w_wr_ptr_nxt = r_wr_ptr + (ADDR_W+1)'(w_wr_ok);
  assign w_rd_ptr_nxt = r_rd_ptr + (ADDR_W+1)'(w_rd_ok);
  // Modulo subtraction of wrap-bit pointers yields occupancy 0..DEPTH.
  assign w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_full        <= 1'b0;
      r_empty       <= 1'b1;
      r_almost_full <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_count       <= w_count_nxt;
      r_full        <= (w_wr_ptr_nxt[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0]) &&
                       (w_wr_ptr_nxt[ADDR_W] != w_rd_ptr_nxt[ADDR_W]);
      r_empty       <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
      r_almost_full <= (w_count_nxt >= C_AF_LEVEL) && (w_count_nxt <= C_DEPTH);
      r_rd_valid    <= w_rd_ok;
      r_overflow    <= wr_en && !w_wr_ok;
      r_underflow   <= rd_en && !w_rd_ok;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset_p (reset_p),
    .we      (w_wr_ok),
    .waddr   (r_wr_ptr[ADDR_W-1:0]),
    .wdata   (wr_data),
    .re      (w_rd_ok),
    .raddr   (r_rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  assign rd_valid    = r_rd_valid;
  assign full        = r_full;
  assign empty       = r_empty;
  assign almost_full = r_almost_full;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sync_fifo                                                 |
// | Description : Queue-model bench for sync_fifo (DEPTH=4, AF_LEVEL=3).       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, overflow, underflow;
  logic [2:0] count;

  int errors = 0;
  int checks = 0;
  bit armed = 1'b0;

  sync_fifo #(.DATA_W(8), .ADDR_W(2), .AF_LEVEL(3)) dut (
    .clk(clk), .reset_p(reset_p), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue plus the last popped word and pulses.
  logic [7:0] q[$];
  logic [7:0] m_rd_data;
  bit         m_rd_valid, m_ovf, m_unf;

  always @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      q.delete();
      m_rd_data  = 8'h00;
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
      m_unf      = 1'b0;
    end else begin
      bit rok, wok;
      rok = rd_en && (q.size() > 0);
      wok = wr_en && ((q.size() < 4) || rok);
      if (rok) m_rd_data = q.pop_front();
      if (wok) q.push_back(wr_data);
      m_rd_valid = rok;
      m_ovf      = wr_en && !wok;
      m_unf      = rd_en && !rok;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed && !reset_p) begin
      chk("m.count",       int'(count),       q.size());
      chk("m.empty",       int'(empty),       int'(q.size() == 0));
      chk("m.full",        int'(full),        int'(q.size() == 4));
      chk("m.almost_full", int'(almost_full), int'(q.size() >= 3));
      chk("m.rd_data",     int'(rd_data),     int'(m_rd_data));
      chk("m.rd_valid",    int'(rd_valid),    int'(m_rd_valid));
      chk("m.overflow",    int'(overflow),    int'(m_ovf));
      chk("m.underflow",   int'(underflow),   int'(m_unf));
    end
  end

  task automatic cyc(input bit we, input logic [7:0] wd, input bit re);
    wr_en = we; wr_data = wd; rd_en = re;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_p = 1'b0;
    armed = 1'b1;
    chk("rst.empty", int'(empty), 1);
    chk("rst.full", int'(full), 0);
    chk("rst.count", int'(count), 0);
    chk("rst.rd_data", int'(rd_data), 0);
    chk("rst.pulses", int'({rd_valid, overflow, underflow}), 0);

    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'hA1 + 8'(i), 1'b0);
      chk("fill.count", int'(count), i + 1);
      chk("fill.af", int'(almost_full), int'(i >= 2));
      chk("fill.full", int'(full), int'(i == 3));
    end
    cyc(1'b1, 8'hFF, 1'b0);
    chk("ovf.pulse", int'(overflow), 1);
    chk("ovf.count", int'(count), 4);
    cyc(1'b0, 8'h00, 1'b0);
    chk("ovf.clear", int'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("drain.data", int'(rd_data), 'hA1 + i);
      chk("drain.valid", int'(rd_valid), 1);
    end
    chk("drain.empty", int'(empty), 1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("unf.pulse", int'(underflow), 1);
    chk("unf.hold", int'(rd_data), 'hA4);
    chk("unf.valid", int'(rd_valid), 0);

    for (int i = 0; i < 4; i++) cyc(1'b1, 8'hD0 + 8'(i), 1'b0);
    cyc(1'b1, 8'hB5, 1'b1);
    chk("simf.count", int'(count), 4);
    chk("simf.data", int'(rd_data), 'hD0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("simf.order", int'(rd_data), (i == 3) ? 'hB5 : 'hD1 + i);
    end

    cyc(1'b1, 8'hC1, 1'b1);
    chk("sime.unf", int'(underflow), 1);
    chk("sime.count", int'(count), 1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("sime.data", int'(rd_data), 'hC1);

    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'(i), i > 0);
      if (i > 0) chk("wrap.data", int'(rd_data), i - 1);
    end
    cyc(1'b0, 8'h00, 1'b1);
    chk("wrap.last", int'(rd_data), 9);

    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h70 + 8'(i), 1'b0);
    @(negedge clk); #1 reset_p = 1'b1;
    #1;
    chk("arst.empty", int'(empty), 1);
    chk("arst.count", int'(count), 0);
    #1 reset_p = 1'b0;
    cyc(1'b1, 8'h5A, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("arst.data", int'(rd_data), 'h5A);

    for (int n = 0; n < 3000; n++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
